// File: rtl/rs_alu_chain_sched.sv
// Two-requester add/subtract unit that evaluates one CHUNK_W-bit carry-chain slice per cycle.
// Optional signed-overflow output res_ovf is enabled by defining RS_ALU_SCHED_OVF_EN.
module rs_alu_chain_sched #(
   parameter int CHUNK_W = 16,
   parameter int NCHUNK  = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req0_valid,
   output logic                        req0_ready,
   input  logic [CHUNK_W*NCHUNK-1:0]   req0_a,
   input  logic [CHUNK_W*NCHUNK-1:0]   req0_b,
   input  logic                        req0_sub,
   input  logic                        req1_valid,
   output logic                        req1_ready,
   input  logic [CHUNK_W*NCHUNK-1:0]   req1_a,
   input  logic [CHUNK_W*NCHUNK-1:0]   req1_b,
   input  logic                        req1_sub,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [CHUNK_W*NCHUNK-1:0]   res_y,
   output logic                        res_co,
`ifdef RS_ALU_SCHED_OVF_EN
   output logic                        res_ovf,
`endif
   output logic                        res_id
);

   localparam int DW = CHUNK_W * NCHUNK;
   localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         r_state;
   logic               r_last;
   logic [DW-1:0]      r_a;
   logic [DW-1:0]      r_b;
   logic               r_sub;
   logic               r_id;
   logic [CW-1:0]      r_cnt;
   logic               r_carry;
   logic [DW-1:0]      r_y;

   logic               w_idle;
   logic               w_grant;
   logic               w_accept;
   logic [CHUNK_W-1:0] w_a_k;
   logic [CHUNK_W-1:0] w_b_k;
   logic [CHUNK_W-1:0] w_bx;
   logic [CHUNK_W:0]   w_sum;
   logic               w_last_chunk;

   // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
   assign w_idle   = (r_state == S_IDLE);
   assign w_grant  = req1_valid && (!req0_valid || !r_last);
   assign w_accept = w_idle && (w_grant ? req1_valid : req0_valid);

   assign req0_ready = w_idle && !w_grant;
   assign req1_ready = w_idle &&  w_grant;

   always_comb begin
      w_a_k = '0;
      w_b_k = '0;
      for (int unsigned k = 0; k < NCHUNK; k++) begin
         if (r_cnt == CW'(k)) begin
            w_a_k = r_a[k*CHUNK_W +: CHUNK_W];
            w_b_k = r_b[k*CHUNK_W +: CHUNK_W];
         end
      end
   end

   assign w_bx         = r_sub ? ~w_b_k : w_b_k;
   assign w_sum        = {1'b0, w_a_k} + {1'b0, w_bx} + {{CHUNK_W{1'b0}}, r_carry};
   assign w_last_chunk = (r_cnt == CW'(NCHUNK - 1));

`ifdef RS_ALU_SCHED_OVF_EN
   logic r_ovf;
   logic w_cin_msb;
   // Carry into the top bit is recovered from the sum bit and its two addend bits.
   assign w_cin_msb = w_a_k[CHUNK_W-1] ^ w_bx[CHUNK_W-1] ^ w_sum[CHUNK_W-1];
   assign res_ovf   = r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == S_BUSY && w_last_chunk) begin
         r_ovf <= w_cin_msb ^ w_sum[CHUNK_W];
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_a     <= '0;
         r_b     <= '0;
         r_sub   <= 1'b0;
         r_id    <= 1'b0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_y     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_a     <= w_grant ? req1_a   : req0_a;
                  r_b     <= w_grant ? req1_b   : req0_b;
                  r_sub   <= w_grant ? req1_sub : req0_sub;
                  r_carry <= w_grant ? req1_sub : req0_sub;
                  r_id    <= w_grant;
                  r_last  <= w_grant;
                  r_cnt   <= '0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               for (int unsigned k = 0; k < NCHUNK; k++) begin
                  if (r_cnt == CW'(k)) begin
                     r_y[k*CHUNK_W +: CHUNK_W] <= w_sum[CHUNK_W-1:0];
                  end
               end
               r_carry <= w_sum[CHUNK_W];
               if (w_last_chunk) begin
                  r_cnt   <= '0;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign res_valid = (r_state == S_DONE);
   assign res_y     = r_y;
   assign res_co    = r_carry;
   assign res_id    = r_id;

endmodule

// File: tb/tb_rs_alu_chain_sched.sv
// Self-checking bench for rs_alu_chain_sched with CHUNK_W=16, NCHUNK=4.
// Expected results come from whole-word 65-bit arithmetic and signed-overflow rules.
module tb_rs_alu_chain_sched;

   localparam int CHUNK_W = 16;
   localparam int NCHUNK  = 4;
   localparam int DW      = CHUNK_W * NCHUNK;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req1_valid;
   logic          req0_ready, req1_ready;
   logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
   logic          req0_sub, req1_sub;
   logic          res_valid, res_ready;
   logic [DW-1:0] res_y;
   logic          res_co;
   logic          res_id;
`ifdef RS_ALU_SCHED_OVF_EN
   logic          res_ovf;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   bit m_last = 1'b1;

   always #5 clk = ~clk;

   rs_alu_chain_sched #(.CHUNK_W(CHUNK_W), .NCHUNK(NCHUNK)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sub   (req0_sub),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sub   (req1_sub),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_y      (res_y),
      .res_co     (res_co),
`ifdef RS_ALU_SCHED_OVF_EN
      .res_ovf    (res_ovf),
`endif
      .res_id     (res_id)
   );

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input bit sub);
      logic [64:0] bb;
      bb = sub ? {1'b0, ~b} : {1'b0, b};
      return {1'b0, a} + bb + {64'd0, sub};
   endfunction

   function automatic bit ref_ovf(input logic [63:0] a, input logic [63:0] b, input bit sub,
                                  input logic [63:0] y);
      if (sub) return (a[63] != b[63]) && (y[63] != a[63]);
      return (a[63] == b[63]) && (y[63] != a[63]);
   endfunction

   function automatic logic [63:0] rand_word();
      logic [63:0] w;
      case ($urandom_range(0, 4))
         0:       w = '0;
         1:       w = '1;
         2:       w = 64'h8000_0000_0000_0000;
         3:       w = 64'h7FFF_FFFF_FFFF_FFFF;
         default: w = {$urandom, $urandom};
      endcase
      return w;
   endfunction

   // Called and returns at 1 time unit after a rising edge.
   task automatic do_reset();
      rst        = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_last = 1'b1;
   endtask

   task automatic issue(input bit v0, input logic [63:0] a0, input logic [63:0] b0, input bit s0,
                        input bit v1, input logic [63:0] a1, input logic [63:0] b1, input bit s1,
                        input int stall);
      bit          g;
      logic [63:0] ea, eb;
      bit          es;
      logic [64:0] r;
      int          lat;
      g  = (v0 && v1) ? ~m_last : v1;
      ea = g ? a1 : a0;
      eb = g ? b1 : b0;
      es = g ? s1 : s0;
      r  = ref_add(ea, eb, es);

      req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
      #1;
      chk_eq("ready0_idle", req0_ready, !g);
      chk_eq("ready1_idle", req1_ready, g);
      m_last = g;
      @(posedge clk);
      #1;
      // Operands move after acceptance; valids stay up to exercise held requests.
      req0_a = rand_word(); req0_b = rand_word(); req0_sub = $urandom_range(0, 1);
      req1_a = rand_word(); req1_b = rand_word(); req1_sub = $urandom_range(0, 1);

      lat = 0;
      while (!res_valid && lat < 20) begin
         chk_eq("ready_busy", {req0_ready, req1_ready}, 2'b00);
         @(posedge clk);
         #1;
         lat++;
      end
      chk_eq("latency", lat, NCHUNK);

      for (int i = 0; i < stall; i++) begin
         chk_eq("valid_hold", res_valid, 1'b1);
         chk_eq("y_hold", res_y, r[63:0]);
         chk_eq("ready_done", {req0_ready, req1_ready}, 2'b00);
         @(posedge clk);
         #1;
      end

      res_ready = 1'b1;
      chk_eq("res_valid", res_valid, 1'b1);
      chk_eq("res_y", res_y, r[63:0]);
      chk_eq("res_co", res_co, r[64]);
      chk_eq("res_id", res_id, g);
`ifdef RS_ALU_SCHED_OVF_EN
      chk_eq("res_ovf", res_ovf, ref_ovf(ea, eb, es, r[63:0]));
`endif
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      chk_eq("valid_after_take", res_valid, 1'b0);
   endtask

   initial begin
      int highs;
      bit v0, v1;

      req0_a = '0; req0_b = '0; req0_sub = 1'b0;
      req1_a = '0; req1_b = '0; req1_sub = 1'b0;
      do_reset();
      chk_eq("rst_valid", res_valid, 1'b0);
      chk_eq("rst_y", res_y, 64'd0);
      chk_eq("rst_co", res_co, 1'b0);
      chk_eq("rst_id", res_id, 1'b0);
`ifdef RS_ALU_SCHED_OVF_EN
      chk_eq("rst_ovf", res_ovf, 1'b0);
`endif
      rst = 1'b0;

      // Carry ripples across a chunk boundary; borrow and no-borrow subtraction.
      issue(1, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 0, 64'd0, 64'd0, 0, 0);
      issue(0, 64'd0, 64'd0, 0, 1, 64'd5, 64'd7, 1, 0);
      issue(0, 64'd0, 64'd0, 0, 1, 64'd7, 64'd5, 1, 1);

      // Fresh reset, then contending requesters alternate starting with requester 0.
      do_reset();
      rst = 1'b0;
      issue(1, 64'd10, 64'd20, 0, 1, 64'd30, 64'd40, 0, 0);
      issue(1, 64'd11, 64'd21, 1, 1, 64'd31, 64'd41, 1, 0);
      issue(1, 64'd12, 64'd22, 0, 1, 64'd32, 64'd42, 1, 0);

      // Long back-pressure in the result stage.
      issue(1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 0, 0, 64'd0, 64'd0, 0, 10);

      // Signed overflow corner cases.
      issue(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 64'd0, 64'd0, 0, 0);
      issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 64'd0, 64'd0, 0, 0);
      issue(1, 64'h8000_0000_0000_0000, 64'd1, 1, 0, 64'd0, 64'd0, 0, 0);

      // Abort an operation during chunk 2.
      req0_valid = 1'b1; req0_a = 64'd3; req0_b = 64'd4; req0_sub = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk_eq("abort_accept", req0_ready, 1'b1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk_eq("ready_in_rst", {req0_ready, req1_ready}, 2'b00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      m_last = 1'b1;
      highs = 0;
      repeat (10) begin
         if (res_valid) highs++;
         @(posedge clk);
         #1;
      end
      chk_eq("abort_no_result", highs, 0);
      issue(1, 64'd1, 64'd1, 0, 0, 64'd0, 64'd0, 0, 0);

      // Immediate acceptance right after reset deasserts, tie goes to requester 0.
      do_reset();
      rst = 1'b0;
      issue(1, 64'd100, 64'd1, 1, 1, 64'd200, 64'd2, 1, 0);

      for (int i = 0; i < 40; i++) begin
         v0 = $urandom_range(0, 1);
         v1 = v0 ? bit'($urandom_range(0, 1)) : 1'b1;
         issue(v0, rand_word(), rand_word(), $urandom_range(0, 1),
               v1, rand_word(), rand_word(), $urandom_range(0, 1),
               $urandom_range(0, 3));
      end

      req0_valid = 1'b0;
      req1_valid = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
